// File: rtl/delta_compressor_stream_pkg.sv
// Shared types and constant helpers for the delta compressor stream.
package delta_comp_pkg;

   typedef enum logic {
      PRIME    = 1'b0,
      COMPRESS = 1'b1
   } dc_state_t;

   // Widest word the symbol helpers can build; callers slice what they need.
   localparam int unsigned MaxWordW = 1024;

   // Bits per delta slot.
   function automatic int unsigned prec(int unsigned data_width, int unsigned delta_slots);
      return data_width / delta_slots;
   endfunction

   // Reserved "no delta" slot symbol: MSB set, remaining bits clear.
   function automatic logic [MaxWordW-1:0] inv_sym(int unsigned p);
      logic [MaxWordW-1:0] s;
      s = '0;
      s[p-1] = 1'b1;
      return s;
   endfunction

   // Empty compression word: every slot holds the reserved symbol.
   function automatic logic [MaxWordW-1:0] nodata_sym(int unsigned data_width,
                                                      int unsigned delta_slots);
      logic [MaxWordW-1:0] s;
      int unsigned         p;
      p = prec(data_width, delta_slots);
      s = '0;
      for (int unsigned k = 0; k < delta_slots; k++) begin
         s = s | (inv_sym(p) << (k * p));
      end
      return s;
   endfunction

   // Symmetric delta range; -2^(p-1) is left out because it encodes INV.
   function automatic longint delta_max(int unsigned p);
      return (longint'(1) << (p - 1)) - longint'(1);
   endfunction

   function automatic longint delta_min(int unsigned p);
      return -delta_max(p);
   endfunction

endpackage

// File: rtl/delta_compressor_stream_if.sv
// Stream bus between vector datapath, compressor and trace buffer.
interface delta_compressor_stream_if #(
   parameter int unsigned N          = 8,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                      valid_in;
   logic                      ready_in;
   logic [N*DATA_WIDTH-1:0]   vector_in;
   logic                      valid_out;
   logic                      ready_out;
   logic [N*DATA_WIDTH-1:0]   vector_out;
   logic                      compressed_out;
   logic                      inc_tb_ptr;
   logic [N*DATA_WIDTH-1:0]   last_vector_out;

   // Environment side: drives input vectors and trace-buffer ready.
   modport master (
      output valid_in,
      input  ready_in,
      output vector_in,
      input  valid_out,
      output ready_out,
      input  vector_out,
      input  compressed_out,
      input  inc_tb_ptr,
      input  last_vector_out
   );

   // Compressor side.
   modport slave (
      input  valid_in,
      output ready_in,
      input  vector_in,
      output valid_out,
      input  ready_out,
      output vector_out,
      output compressed_out,
      output inc_tb_ptr,
      output last_vector_out
   );
endinterface

// File: rtl/delta_compressor_stream_lane_packer.sv
// One lane of the compressor: computes the delta against the base, checks it
// fits a slot, and inserts it into the lane's compression word at slot ptr.
module delta_lane_packer
   import delta_comp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DELTA_SLOTS = 4,
   parameter int unsigned PTR_W       = 2
) (
   input  logic [DATA_WIDTH-1:0] cur_i,
   input  logic [DATA_WIDTH-1:0] last_i,
   input  logic [DATA_WIDTH-1:0] comp_i,
   input  logic [PTR_W-1:0]      ptr_i,
   output logic                  fit_o,
   output logic [DATA_WIDTH-1:0] packed_o
);

   localparam int unsigned Prec = prec(DATA_WIDTH, DELTA_SLOTS);
   localparam logic signed [DATA_WIDTH-1:0] DeltaMax = DATA_WIDTH'(delta_max(Prec));
   localparam logic signed [DATA_WIDTH-1:0] DeltaMin = DATA_WIDTH'(delta_min(Prec));

   logic [DATA_WIDTH-1:0] delta;

   // Modular subtraction, then read as signed for the range test.
   assign delta = cur_i - last_i;
   assign fit_o = ($signed(delta) >= DeltaMin) && ($signed(delta) <= DeltaMax);

   // Slot 0 sits at the MSBs; untouched slots keep whatever comp_i holds.
   always_comb begin
      packed_o = comp_i;
      for (int unsigned k = 0; k < DELTA_SLOTS; k++) begin
         if (ptr_i == PTR_W'(k)) begin
            packed_o[DATA_WIDTH-1-k*Prec -: Prec] = delta[Prec-1:0];
         end
      end
   end

endmodule

// File: rtl/delta_compressor_stream.sv
// Per-lane delta compressor: emits each accepted vector raw (keyframe) or as
// signed deltas packed into a per-lane compression word for the trace buffer.
module delta_compressor_stream
   import delta_comp_pkg::*;
#(
   parameter int unsigned N                 = 8,
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned DELTA_SLOTS       = 4,
   parameter int unsigned KEYFRAME_INTERVAL = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tracing,
   input  logic                          bypass,
   delta_compressor_stream_if.slave      bus
);

   localparam int unsigned PtrW = (DELTA_SLOTS > 1) ? $clog2(DELTA_SLOTS) : 1;
   localparam int unsigned KfW  = (KEYFRAME_INTERVAL > 0) ? $clog2(KEYFRAME_INTERVAL + 1) : 1;
   localparam logic [MaxWordW-1:0]   NodataFull = nodata_sym(DATA_WIDTH, DELTA_SLOTS);
   localparam logic [DATA_WIDTH-1:0] Nodata     = NodataFull[DATA_WIDTH-1:0];

   dc_state_t                state_q;
   logic [PtrW-1:0]          ptr_q;
   logic [KfW-1:0]           kf_cnt_q;
   logic [DATA_WIDTH-1:0]    comp_q [N];
   logic [N*DATA_WIDTH-1:0]  last_q;
   logic                     valid_out_q;
   logic [N*DATA_WIDTH-1:0]  vector_out_q;
   logic                     compressed_q;
   logic                     inc_tb_ptr_q;

   logic [DATA_WIDTH-1:0]    packed_w [N];
   logic [N*DATA_WIDTH-1:0]  packed_vec;
   logic [N-1:0]             fit_lane;
   logic                     fit_all;
   logic                     ready;
   logic                     accept;
   logic                     keyframe_due;
   logic                     ptr_wrap;
   logic                     take_raw;

   for (genvar i = 0; i < N; i++) begin : g_lane
      delta_lane_packer #(
         .DATA_WIDTH  (DATA_WIDTH),
         .DELTA_SLOTS (DELTA_SLOTS),
         .PTR_W       (PtrW)
      ) u_packer (
         .cur_i    (bus.vector_in[i*DATA_WIDTH +: DATA_WIDTH]),
         .last_i   (last_q[i*DATA_WIDTH +: DATA_WIDTH]),
         .comp_i   (comp_q[i]),
         .ptr_i    (ptr_q),
         .fit_o    (fit_lane[i]),
         .packed_o (packed_w[i])
      );
      assign packed_vec[i*DATA_WIDTH +: DATA_WIDTH] = packed_w[i];
   end

   assign fit_all      = &fit_lane;
   assign ready        = !valid_out_q || bus.ready_out;
   assign accept       = bus.valid_in && ready && tracing;
   assign keyframe_due = (KEYFRAME_INTERVAL != 0) && (kf_cnt_q == KfW'(KEYFRAME_INTERVAL));
   assign ptr_wrap     = (ptr_q == PtrW'(DELTA_SLOTS - 1));
   assign take_raw     = !fit_all || bypass || keyframe_due;

   // FSM, handshake and output registers; outputs only change on an accept,
   // so a stalled word stays stable until the trace buffer takes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= PRIME;
         ptr_q        <= '0;
         kf_cnt_q     <= '0;
         last_q       <= '0;
         valid_out_q  <= 1'b0;
         vector_out_q <= '0;
         compressed_q <= 1'b0;
         inc_tb_ptr_q <= 1'b0;
         for (int i = 0; i < N; i++) comp_q[i] <= Nodata;
      end else begin
         if (valid_out_q && bus.ready_out) valid_out_q <= 1'b0;

         if (!tracing) begin
            state_q  <= PRIME;
            ptr_q    <= '0;
            kf_cnt_q <= '0;
            for (int i = 0; i < N; i++) comp_q[i] <= Nodata;
         end else if (accept) begin
            valid_out_q <= 1'b1;
            last_q      <= bus.vector_in;
            if (state_q == PRIME || take_raw) begin
               state_q      <= COMPRESS;
               vector_out_q <= bus.vector_in;
               compressed_q <= 1'b0;
               inc_tb_ptr_q <= 1'b1;
               ptr_q        <= '0;
               kf_cnt_q     <= '0;
               for (int i = 0; i < N; i++) comp_q[i] <= Nodata;
            end else begin
               vector_out_q <= packed_vec;
               compressed_q <= 1'b1;
               // Later slots rewrite the same trace-buffer entry.
               inc_tb_ptr_q <= (ptr_q == '0);
               ptr_q        <= ptr_wrap ? '0 : ptr_q + 1'b1;
               kf_cnt_q     <= kf_cnt_q + 1'b1;
               for (int i = 0; i < N; i++) comp_q[i] <= ptr_wrap ? Nodata : packed_w[i];
            end
         end
      end
   end

   assign bus.ready_in        = ready;
   assign bus.valid_out       = valid_out_q;
   assign bus.vector_out      = vector_out_q;
   assign bus.compressed_out  = compressed_q;
   assign bus.inc_tb_ptr      = inc_tb_ptr_q;
   assign bus.last_vector_out = last_q;

endmodule
